// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART baud table, counter width and receiver states.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int C_CNT_W = 11;

    localparam logic [C_CNT_W-1:0] C_DIV_000 = 11'd1042;
    localparam logic [C_CNT_W-1:0] C_DIV_001 = 11'd695;
    localparam logic [C_CNT_W-1:0] C_DIV_010 = 11'd521;
    localparam logic [C_CNT_W-1:0] C_DIV_011 = 11'd261;
    localparam logic [C_CNT_W-1:0] C_DIV_100 = 11'd174;
    localparam logic [C_CNT_W-1:0] C_DIV_101 = 11'd87;
    localparam logic [C_CNT_W-1:0] C_DIV_110 = 11'd79;
    localparam logic [C_CNT_W-1:0] C_DIV_111 = 11'd39;

    localparam logic [2:0] RX_IDLE  = 3'd0;
    localparam logic [2:0] RX_START = 3'd1;
    localparam logic [2:0] RX_DATA  = 3'd2;
    localparam logic [2:0] RX_STOP  = 3'd3;
    localparam logic [2:0] RX_BREAK = 3'd4;

    function automatic logic [C_CNT_W-1:0] baud_div(input logic [2:0] sel);
        case (sel)
            3'b000:  return C_DIV_000;
            3'b001:  return C_DIV_001;
            3'b010:  return C_DIV_010;
            3'b011:  return C_DIV_011;
            3'b100:  return C_DIV_100;
            3'b101:  return C_DIV_101;
            3'b110:  return C_DIV_110;
            default: return C_DIV_111;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_lut.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_lut
// Description : Combinational baud select to clocks-per-bit divisor.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_lut
    import uart_pkg::*;
(
    input  logic [2:0]         i_baud_sel,
    output logic [C_CNT_W-1:0] o_div
);

    always_comb begin
        o_div = baud_div(i_baud_sel);
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver, mid-bit sampling, valid and framing strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] baud_rate_select,
    input  logic       Rx_Serial,
    output logic [7:0] Rx_Byte,
    output logic       Rx_Valid,
    output logic       Rx_Frame_Err,
    output logic       Rx_Active
);

    logic               r_s1_q, r_s2_q;
    logic [2:0]         r_state_q, w_state_d;
    logic [C_CNT_W-1:0] r_cnt_q, w_cnt_d;
    logic [2:0]         r_bit_idx_q, w_bit_idx_d;
    logic [7:0]         r_shift_q, w_shift_d;
    logic [C_CNT_W-1:0] r_div_q, w_div_d;
    logic [7:0]         r_byte_q, w_byte_d;
    logic               r_valid_q, w_valid_d;
    logic               r_ferr_q, w_ferr_d;

    logic [C_CNT_W-1:0] w_lut_div;
    logic [C_CNT_W-1:0] w_half;
    logic               w_half_hit;
    logic               w_bit_hit;

    uart_baud_lut u_baud_lut (
        .i_baud_sel (baud_rate_select),
        .o_div      (w_lut_div)
    );

    assign w_half     = r_div_q >> 1;
    assign w_half_hit = (r_cnt_q == w_half - 11'd1);
    assign w_bit_hit  = (r_cnt_q == r_div_q - 11'd1);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1_q      <= 1'b1;
            r_s2_q      <= 1'b1;
            r_state_q   <= RX_IDLE;
            r_cnt_q     <= '0;
            r_bit_idx_q <= '0;
            r_shift_q   <= '0;
            r_div_q     <= C_DIV_000;
            r_byte_q    <= '0;
            r_valid_q   <= 1'b0;
            r_ferr_q    <= 1'b0;
        end else begin
            r_s1_q      <= Rx_Serial;
            r_s2_q      <= r_s1_q;
            r_state_q   <= w_state_d;
            r_cnt_q     <= w_cnt_d;
            r_bit_idx_q <= w_bit_idx_d;
            r_shift_q   <= w_shift_d;
            r_div_q     <= w_div_d;
            r_byte_q    <= w_byte_d;
            r_valid_q   <= w_valid_d;
            r_ferr_q    <= w_ferr_d;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            RX_IDLE:  if (!r_s2_q) w_state_d = RX_START;
            RX_START: if (w_half_hit) w_state_d = r_s2_q ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_bit_hit && r_bit_idx_q == 3'd7) w_state_d = RX_STOP;
            RX_STOP:  if (w_bit_hit) w_state_d = r_s2_q ? RX_IDLE : RX_BREAK;
            RX_BREAK: if (r_s2_q) w_state_d = RX_IDLE;
            default:  w_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        w_cnt_d     = r_cnt_q + 11'd1;
        w_bit_idx_d = r_bit_idx_q;
        w_shift_d   = r_shift_q;
        w_div_d     = r_div_q;
        w_byte_d    = r_byte_q;
        w_valid_d   = 1'b0;
        w_ferr_d    = 1'b0;
        case (r_state_q)
            RX_IDLE: begin
                w_cnt_d     = '0;
                w_bit_idx_d = '0;
                // Divisor is frozen for the whole frame from here on.
                if (!r_s2_q) w_div_d = w_lut_div;
            end
            RX_START: begin
                if (w_half_hit) w_cnt_d = '0;
            end
            RX_DATA: begin
                if (w_bit_hit) begin
                    w_shift_d[r_bit_idx_q] = r_s2_q;
                    w_cnt_d                = '0;
                    w_bit_idx_d            = r_bit_idx_q + 3'd1;
                end
            end
            RX_STOP: begin
                if (w_bit_hit) begin
                    w_cnt_d = '0;
                    if (r_s2_q) begin
                        w_byte_d  = r_shift_q;
                        w_valid_d = 1'b1;
                    end else begin
                        w_ferr_d = 1'b1;
                    end
                end
            end
            default: begin
                w_cnt_d     = '0;
                w_bit_idx_d = '0;
            end
        endcase
    end

    assign Rx_Byte      = r_byte_q;
    assign Rx_Valid     = r_valid_q;
    assign Rx_Frame_Err = r_ferr_q;
    assign Rx_Active    = (r_state_q != RX_IDLE);

endmodule
`default_nettype wire
